// File: rtl/alu_seq.sv
// alu_seq: multi-cycle, handshaked ALU.
//   ADD/SUB/AND/NAND/OR/XOR/CMP/NOT and illegal codes finish in one cycle.
//   MUL (shift-add) and DIV (restoring) iterate for WIDTH_DATA EXEC cycles.
//   Optional feature macro: ALU_SEQ_MOD_EN enables op 14 MOD (DIV remainder);
//   without it op 14 is treated as illegal.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   operand_a, operand_b  unsigned operands, latched on acceptance
//   op_code               5-bit operation code
//   out_valid / out_ready result handshake; result and flags held until accepted
//   result                registered result
//   flag_zero, flag_neg, flag_carry, flag_ovf, flag_dz, flag_ill   status flags
module alu_seq #(
  parameter int WIDTH_DATA = 32,
  parameter int CNT_W      = $clog2(WIDTH_DATA + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_DATA-1:0] operand_a,
  input  logic [WIDTH_DATA-1:0] operand_b,
  input  logic [4:0]            op_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] result,
  output logic                  flag_zero,
  output logic                  flag_neg,
  output logic                  flag_carry,
  output logic                  flag_ovf,
  output logic                  flag_dz,
  output logic                  flag_ill
);

  localparam int W = WIDTH_DATA;

  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_NAND = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_CMP  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;
`ifdef ALU_SEQ_MOD_EN
  localparam logic [4:0] OP_MOD  = 5'd14;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t           r_state;
  logic [4:0]       r_op;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_hi;   // MUL: product high half; DIV: partial remainder
  logic [W-1:0]     r_lo;   // MUL: multiplier/product low half; DIV: dividend/quotient
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic             r_out_valid, r_zero, r_neg, r_carry, r_ovf, r_dz, r_ill;

  // single-cycle datapath, evaluated on the live inputs at acceptance
  logic [W:0]   w_add, w_sub;
  logic [W-1:0] w_res;
  logic         w_carry, w_ovf, w_ill, w_dz, w_iter;

  always_comb begin
    w_add   = {1'b0, operand_a} + {1'b0, operand_b};
    w_sub   = {1'b0, operand_a} - {1'b0, operand_b};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    w_dz    = 1'b0;
    w_iter  = 1'b0;
    case (op_code)
      OP_ADD: begin
        w_res   = w_add[W-1:0];
        w_carry = w_add[W];
        w_ovf   = (operand_a[W-1] == operand_b[W-1]) && (w_add[W-1] != operand_a[W-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[W-1:0];
        w_carry = w_sub[W];
        w_ovf   = (operand_a[W-1] != operand_b[W-1]) && (w_sub[W-1] != operand_a[W-1]);
      end
      OP_MUL: w_iter = 1'b1;
      OP_DIV: begin
        if (operand_b == '0) w_dz = 1'b1;
        else                 w_iter = 1'b1;
      end
`ifdef ALU_SEQ_MOD_EN
      OP_MOD: begin
        if (operand_b == '0) w_dz = 1'b1;
        else                 w_iter = 1'b1;
      end
`endif
      OP_AND:  w_res = operand_a & operand_b;
      OP_NAND: w_res = ~(operand_a & operand_b);
      OP_OR:   w_res = operand_a | operand_b;
      OP_XOR:  w_res = operand_a ^ operand_b;
      OP_CMP: begin
        if (operand_a == operand_b)     w_res = '0;
        else if (operand_a > operand_b) w_res = W'(1);
        else                            w_res = '1;
      end
      OP_NOT:  w_res = ~operand_a;
      default: w_ill = 1'b1;
    endcase
  end

  // one iteration step of the shared MUL / DIV unit
  logic [W:0]   w_madd, w_shift, w_diff;
  logic [W-1:0] w_hi_nxt, w_lo_nxt, w_fin;

  always_comb begin
    w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[W-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op == OP_MUL) begin
      // add multiplicand on multiplier LSB, then shift {carry,hi,lo} right
      w_hi_nxt = w_madd[W:1];
      w_lo_nxt = {w_madd[0], r_lo[W-1:1]};
    end else if (!w_diff[W]) begin
      // trial subtraction fits: keep it, quotient bit 1
      w_hi_nxt = w_diff[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_shift[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], 1'b0};
    end
`ifdef ALU_SEQ_MOD_EN
    w_fin = (r_op == OP_MOD) ? w_hi_nxt : w_lo_nxt;
`else
    w_fin = w_lo_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op  <= op_code;
            r_b   <= operand_b;
            r_hi  <= '0;
            r_lo  <= operand_a;
            r_cnt <= '0;
            if (w_iter) begin
              r_state <= ST_EXEC;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_zero      <= !w_ill && (w_res == '0);
              r_neg       <= w_res[W-1];
              r_carry     <= w_carry;
              r_ovf       <= w_ovf;
              r_dz        <= w_dz;
              r_ill       <= w_ill;
            end
          end
        end
        ST_EXEC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_fin;
            r_zero      <= (w_fin == '0);
            r_neg       <= w_fin[W-1];
            r_carry     <= 1'b0;
            r_ovf       <= (r_op == OP_MUL) && (w_hi_nxt != '0);
            r_dz        <= 1'b0;
            r_ill       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign flag_zero  = r_zero;
  assign flag_neg   = r_neg;
  assign flag_carry = r_carry;
  assign flag_ovf   = r_ovf;
  assign flag_dz    = r_dz;
  assign flag_ill   = r_ill;

endmodule
